// File: rtl/raspi_interface_pkg.sv
// Shared constants for the Raspberry Pi parallel-bus bridge: bus control words,
// transmit FSM state encoding and the receive FIFO entry layout.
package raspi_interface_pkg;

  localparam logic [8:0] WORD_ESC  = 9'h1ff;
  localparam logic [8:0] WORD_SYNC = 9'h0ff;
  localparam logic [8:0] HDR_FLAG  = 9'h100;

  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_HDR  = 2'd1;
  localparam logic [1:0] TX_DATA = 2'd2;
  localparam logic [1:0] TX_LAST = 2'd3;

  typedef struct packed {
    logic [7:0] ep;
    logic [7:0] data;
  } recv_entry_t;

endpackage

// File: rtl/raspi_fifo.sv
// Synchronous show-ahead FIFO; a push while full is accepted only if a pop
// happens in the same cycle.
module raspi_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/raspi_interface.sv
// Bridges the 9-bit Raspberry Pi strobe bus into per-endpoint receive bytes
// and framed (header, data..., 1ff) transmit words returned on host reads.
module raspi_interface
  import raspi_interface_pkg::*;
#(
  parameter int RECV_FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       raspi_clk,
  input  logic       raspi_dir,
  input  logic [8:0] raspi_dat_in,
  output logic [8:0] raspi_dat_out,
  output logic       raspi_dat_oe,
  output logic       recv_valid,
  output logic [7:0] recv_ep,
  output logic [7:0] recv_data,
  input  logic       recv_ready,
  output logic       recv_overflow,
  input  logic       send_valid,
  input  logic [7:0] send_ep,
  input  logic [7:0] send_data,
  input  logic       send_last,
  output logic       send_ready,
  output logic       sync_pulse
);

  logic       clk_s1_q, clk_s2_q, clk_s3_q;
  logic       dir_s1_q, dir_s2_q;
  logic       rise, wr_rise, rd_rise;
  logic [8:0] wr_word;

  // Dir flops reset to "host writes" so the pad stays tri-stated in reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_s1_q <= 1'b0;
      clk_s2_q <= 1'b0;
      clk_s3_q <= 1'b0;
      dir_s1_q <= 1'b1;
      dir_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= raspi_clk;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dir_s1_q <= raspi_dir;
      dir_s2_q <= dir_s1_q;
    end
  end

  assign rise    = clk_s2_q & ~clk_s3_q;
  assign wr_rise = rise & dir_s2_q;
  assign rd_rise = rise & ~dir_s2_q;
  assign wr_word = raspi_dat_in;

  assign raspi_dat_oe = ~dir_s2_q;

  logic        sel_q, esc_q, sync_q, ovf_q;
  logic [7:0]  ep_q;
  logic        is_esc, is_sync, is_sel, is_data;
  logic        sync_cmd, push_req;
  logic        fifo_full, fifo_empty, fifo_pop;
  recv_entry_t push_entry, pop_entry;

  assign is_esc   = (wr_word == WORD_ESC);
  assign is_sync  = esc_q && (wr_word == WORD_SYNC);
  assign is_sel   = wr_word[8] && !is_esc;
  assign is_data  = !wr_word[8] && sel_q && !is_sync;
  assign sync_cmd = wr_rise & is_sync;
  assign push_req = wr_rise & is_data;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_q  <= 1'b0;
      esc_q  <= 1'b0;
      ep_q   <= '0;
      sync_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= sync_cmd;
      if (wr_rise) begin
        esc_q <= is_esc;
        if (is_esc) begin
          sel_q <= 1'b0;
        end else if (is_sel) begin
          sel_q <= 1'b1;
          ep_q  <= wr_word[7:0];
        end
      end
      if (push_req && fifo_full && !fifo_pop) ovf_q <= 1'b1;
    end
  end

  assign push_entry = {ep_q, wr_word[7:0]};
  assign fifo_pop   = recv_valid & recv_ready;

  raspi_fifo #(
    .WIDTH ($bits(recv_entry_t)),
    .DEPTH (RECV_FIFO_DEPTH)
  ) u_recv_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (push_req),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .pop_data_o  (pop_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign recv_valid    = ~fifo_empty;
  assign recv_ep       = fifo_empty ? 8'h00 : pop_entry.ep;
  assign recv_data     = fifo_empty ? 8'h00 : pop_entry.data;
  assign recv_overflow = ovf_q;
  assign sync_pulse    = sync_q;

  logic [1:0] tx_state_q, tx_state_d;
  logic [8:0] dat_q, dat_d;
  logic       send_ready_c;

  // Each read rise hands out dat_q and preloads the word for the next read.
  always_comb begin
    tx_state_d   = tx_state_q;
    dat_d        = dat_q;
    send_ready_c = 1'b0;
    if (sync_cmd) begin
      tx_state_d = TX_IDLE;
      dat_d      = WORD_ESC;
    end else if (rd_rise) begin
      case (tx_state_q)
        TX_IDLE: begin
          if (send_valid) begin
            dat_d      = HDR_FLAG | {1'b0, send_ep};
            tx_state_d = TX_HDR;
          end else begin
            dat_d = WORD_ESC;
          end
        end
        TX_HDR, TX_DATA: begin
          if (send_valid) begin
            dat_d        = {1'b0, send_data};
            send_ready_c = 1'b1;
            tx_state_d   = send_last ? TX_LAST : TX_DATA;
          end else begin
            dat_d      = WORD_ESC;
            tx_state_d = TX_IDLE;
          end
        end
        default: begin
          dat_d      = WORD_ESC;
          tx_state_d = TX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_state_q <= TX_IDLE;
      dat_q      <= WORD_ESC;
    end else begin
      tx_state_q <= tx_state_d;
      dat_q      <= dat_d;
    end
  end

  assign raspi_dat_out = dat_q;
  assign send_ready    = send_ready_c;

endmodule

// File: tb/tb_raspi_interface.sv
// Randomised host-bus bench for raspi_interface: a host model drives strobed
// reads/writes, an endpoint model offers packets, and a queue model predicts rx.
module tb_raspi_interface;

  logic       clk = 1'b0;
  logic       resetn;
  logic       raspi_clk, raspi_dir;
  logic [8:0] raspi_dat_in, raspi_dat_out;
  logic       raspi_dat_oe;
  logic       recv_valid, recv_ready, recv_overflow;
  logic [7:0] recv_ep, recv_data;
  logic       send_valid, send_last, send_ready, sync_pulse;
  logic [7:0] send_ep, send_data;

  always #5 clk = ~clk;

  raspi_interface #(.RECV_FIFO_DEPTH(16)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .raspi_clk     (raspi_clk),
    .raspi_dir     (raspi_dir),
    .raspi_dat_in  (raspi_dat_in),
    .raspi_dat_out (raspi_dat_out),
    .raspi_dat_oe  (raspi_dat_oe),
    .recv_valid    (recv_valid),
    .recv_ep       (recv_ep),
    .recv_data     (recv_data),
    .recv_ready    (recv_ready),
    .recv_overflow (recv_overflow),
    .send_valid    (send_valid),
    .send_ep       (send_ep),
    .send_data     (send_data),
    .send_last     (send_last),
    .send_ready    (send_ready),
    .sync_pulse    (sync_pulse)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("check %s: %0h", tag, got);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Endpoint model: bit 8 of each queued entry marks the last byte of a packet.
  logic [8:0] tx_q[$];
  bit         consumed = 0;
  int         rdy_cnt = 0;
  int         sync_cnt = 0;

  always @(negedge clk) begin
    if (send_ready) begin
      rdy_cnt++;
      consumed = 1;
    end
    if (sync_pulse) sync_cnt++;
  end

  always @(posedge clk) begin
    #1;
    if (consumed) begin
      consumed = 0;
      if (tx_q.size() > 0) void'(tx_q.pop_front());
    end
    if (tx_q.size() > 0) begin
      send_valid = 1'b1;
      send_data  = tx_q[0][7:0];
      send_last  = tx_q[0][8];
    end else begin
      send_valid = 1'b0;
      send_data  = 8'h00;
      send_last  = 1'b0;
    end
  end

  // Receive-side reference model: endpoint selection, escape and a bounded queue.
  bit          m_sel = 0, m_esc = 0, m_ovf = 0;
  logic [7:0]  m_ep = 8'h00;
  logic [15:0] m_q[$];
  int          m_sync = 0;

  task automatic model_write(logic [8:0] w);
    if (w == 9'h1ff) begin
      m_sel = 0;
      m_esc = 1;
    end else begin
      if (w == 9'h0ff && m_esc) m_sync++;
      else if (w[8]) begin
        m_sel = 1;
        m_ep  = w[7:0];
      end else if (m_sel) begin
        if (m_q.size() < 16) m_q.push_back({m_ep, w[7:0]});
        else m_ovf = 1;
      end
      m_esc = 0;
    end
  endtask

  task automatic model_reset();
    m_sel = 0; m_esc = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic host_write(logic [8:0] w);
    raspi_dir    = 1'b1;
    raspi_dat_in = w;
    tick(3);
    raspi_clk = 1'b1;
    tick(4);
    raspi_clk = 1'b0;
    tick(3);
    model_write(w);
  endtask

  task automatic host_read(output logic [8:0] w);
    raspi_dir = 1'b0;
    tick(3);
    w = raspi_dat_out;
    check_eq("read_oe", raspi_dat_oe, 1'b1);
    raspi_clk = 1'b1;
    tick(4);
    raspi_clk = 1'b0;
    tick(3);
  endtask

  task automatic read_expect(string tag, logic [8:0] exp);
    logic [8:0] w;
    host_read(w);
    check_eq(tag, w, exp);
  endtask

  task automatic pop_check();
    logic [15:0] e;
    e = m_q.pop_front();
    check_eq("pop_valid", recv_valid, 1'b1);
    check_eq("pop_ep", recv_ep, e[15:8]);
    check_eq("pop_data", recv_data, e[7:0]);
    recv_ready = 1'b1;
    tick(1);
    recv_ready = 1'b0;
  endtask

  task automatic drain_all();
    while (m_q.size() > 0) pop_check();
    check_eq("drain_empty", recv_valid, 1'b0);
  endtask

  task automatic load_packet(int n, output logic [7:0] bytes[$]);
    bytes.delete();
    for (int i = 0; i < n; i++) begin
      bytes.push_back(8'($urandom_range(0, 255)));
      tx_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, bytes[i]});
    end
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] bytes[$];
    logic [7:0] ep;
    int         base, k, n;

    resetn = 1'b0; raspi_clk = 1'b0; raspi_dir = 1'b1; raspi_dat_in = 9'h000;
    recv_ready = 1'b0; send_ep = 8'h00;
    tick(4);
    check_eq("rst_dat_out", raspi_dat_out, 9'h1ff);
    check_eq("rst_oe", raspi_dat_oe, 1'b0);
    check_eq("rst_recv_valid", recv_valid, 1'b0);
    check_eq("rst_recv_ep", recv_ep, 8'h00);
    check_eq("rst_overflow", recv_overflow, 1'b0);
    check_eq("rst_sync", sync_pulse, 1'b0);
    check_eq("rst_send_ready", send_ready, 1'b0);
    resetn = 1'b1;
    tick(3);

    // 1: idle reads
    for (int i = 0; i < 3; i++) read_expect("t1_idle_read", 9'h1ff);
    check_eq("t1_recv_valid", recv_valid, 1'b0);
    check_eq("t1_ready_cnt", rdy_cnt, 0);

    // 2: sync command then ordered receive, plus a random endpoint burst
    host_write(9'h1ff);
    host_write(9'h0ff);
    check_eq("t2_sync_cnt", sync_cnt, m_sync);
    check_eq("t2_sync_once", sync_cnt, 1);
    host_write(9'h100);
    for (int i = 0; i < 4; i++) host_write(9'h040 + 9'(i));
    ep = 8'($urandom_range(0, 254));
    host_write({1'b1, ep});
    for (int i = 0; i < 6; i++) host_write({1'b0, 8'($urandom_range(0, 255))});
    host_write(9'h1ff);
    host_write(9'h033);
    check_eq("t2_fifo_level", m_q.size(), 10);
    drain_all();
    check_eq("t2_overflow", recv_overflow, m_ovf);

    // 3: 64-byte packet on endpoint 00
    send_ep = 8'h00;
    base = rdy_cnt;
    load_packet(64, bytes);
    read_expect("t3_pre", 9'h1ff);
    read_expect("t3_hdr", 9'h100);
    for (int i = 0; i < 64; i++) read_expect("t3_data", {1'b0, bytes[i]});
    read_expect("t3_tail", 9'h1ff);
    check_eq("t3_ready_cnt", rdy_cnt - base, 64);

    // 4: overflow on endpoint 01
    host_write(9'h101);
    for (int i = 0; i < 20; i++) host_write({1'b0, 8'($urandom_range(0, 255))});
    check_eq("t4_overflow", recv_overflow, m_ovf);
    check_eq("t4_overflow_set", recv_overflow, 1'b1);
    drain_all();

    // 5: sync abort mid-packet restarts with a fresh header
    ep = 8'($urandom_range(0, 255));
    send_ep = ep;
    n = 20;
    k = $urandom_range(2, 8);
    base = rdy_cnt;
    load_packet(n, bytes);
    read_expect("t5_pre", 9'h1ff);
    read_expect("t5_hdr", {1'b1, ep});
    for (int i = 0; i < k; i++) read_expect("t5_data", {1'b0, bytes[i]});
    host_write(9'h1ff);
    host_write(9'h0ff);
    check_eq("t5_sync_cnt", sync_cnt, m_sync);
    read_expect("t5_abort", 9'h1ff);
    read_expect("t5_rehdr", {1'b1, ep});
    for (int i = k + 1; i < n; i++) read_expect("t5_rest", {1'b0, bytes[i]});
    read_expect("t5_tail", 9'h1ff);
    check_eq("t5_ready_cnt", rdy_cnt - base, n);

    // 6: reset in the middle of a packet with the FIFO occupied
    host_write(9'h103);
    for (int i = 0; i < 3; i++) host_write({1'b0, 8'($urandom_range(0, 255))});
    check_eq("t6_pre_valid", recv_valid, 1'b1);
    send_ep = 8'h00;
    load_packet(30, bytes);
    read_expect("t6_pre", 9'h1ff);
    read_expect("t6_hdr", 9'h100);
    read_expect("t6_data", {1'b0, bytes[0]});
    resetn = 1'b0;
    tx_q.delete();
    consumed = 0;
    tick(1);
    resetn = 1'b1;
    model_reset();
    tick(3);
    check_eq("t6_recv_valid", recv_valid, 1'b0);
    check_eq("t6_overflow", recv_overflow, 1'b0);
    read_expect("t6_post_read", 9'h1ff);
    host_write(9'h055);
    check_eq("t6_deselected", recv_valid, (m_q.size() > 0) ? 1'b1 : 1'b0);
    read_expect("t6_idle_read", 9'h1ff);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
